// File: rtl/can_pkg.sv
// Shared CAN identifier definitions: field widths, recessive level and the
// identifier serializer FSM state encoding.
package can_pkg;

  localparam int unsigned ID_WIDTH     = 11;
  localparam int unsigned ID_CNT_WIDTH = 4;
  localparam logic        RECESSIVE    = 1'b1;

  localparam logic [ID_CNT_WIDTH-1:0] ID_BITS = ID_CNT_WIDTH'(ID_WIDTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    COMPLETE = 2'd2
  } state_e;

endpackage

// File: rtl/can_identifier.sv
// CAN base-identifier serializer: shifts the 11-bit identifier out MSB-first,
// one bit per sample_point. Optional macro ID_VALID_CHECK_EN rejects 7'h7F prefixes.
module can_identifier
  import can_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    sample_point,
  input  logic                    tx_request,
  input  logic                    sof_complete,
  input  logic [ID_WIDTH-1:0]     identifier,
  output logic                    bit_id,
  output logic [ID_CNT_WIDTH-1:0] bit_counter,
  output logic                    id_complete
);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     shreg_q, shreg_d;
  logic                    bit_id_q, bit_id_d;
  logic [ID_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    req_ok;
  logic                    id_valid;

`ifdef ID_VALID_CHECK_EN
  assign id_valid = (identifier[ID_WIDTH-1:ID_WIDTH-7] != '1);
`else
  assign id_valid = 1'b1;
`endif

  assign req_ok = tx_request && sof_complete;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bit_id_d = bit_id_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    unique case (state_q)
      IDLE: begin
        bit_id_d = RECESSIVE;
        cnt_d    = '0;
        done_d   = 1'b0;
        if (req_ok && id_valid) begin
          state_d  = TRANSMIT;
          shreg_d  = identifier;
          bit_id_d = identifier[ID_WIDTH-1];
        end
      end
      TRANSMIT: begin
        if (!req_ok) begin
          state_d  = IDLE;
          bit_id_d = RECESSIVE;
          cnt_d    = '0;
          done_d   = 1'b0;
        end else if (sample_point) begin
          cnt_d = cnt_q + 1'b1;
          // Last sample keeps identifier[0] on the bus instead of shifting on.
          if (cnt_q == ID_BITS - 1'b1) begin
            state_d = COMPLETE;
            done_d  = 1'b1;
          end else begin
            shreg_d  = shreg_q << 1;
            bit_id_d = shreg_d[ID_WIDTH-1];
          end
        end
      end
      COMPLETE: begin
        if (!req_ok) begin
          state_d  = IDLE;
          bit_id_d = RECESSIVE;
          cnt_d    = '0;
          done_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        bit_id_d = RECESSIVE;
        cnt_d    = '0;
        done_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_id_q <= RECESSIVE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else if (enable) begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_id_q <= bit_id_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign bit_id      = bit_id_q;
  assign bit_counter = cnt_q;
  assign id_complete = done_q;

endmodule

// File: tb/tb_can_identifier.sv
// Directed self-checking bench for can_identifier (default build; expectations
// for the 7FF case follow ID_VALID_CHECK_EN when it is defined).
module tb_can_identifier;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_point;
  logic        tx_request;
  logic        sof_complete;
  logic [10:0] identifier;
  logic        bit_id;
  logic [3:0]  bit_counter;
  logic        id_complete;

  int checks   = 0;
  int failures = 0;

  can_identifier dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_point (sample_point),
    .tx_request   (tx_request),
    .sof_complete (sof_complete),
    .identifier   (identifier),
    .bit_id       (bit_id),
    .bit_counter  (bit_counter),
    .id_complete  (id_complete)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_sample();
    sample_point = 1'b1;
    tick();
    sample_point = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic eb, input logic [3:0] ec, input logic ed);
    checks++;
    if ({bit_id, bit_counter, id_complete} !== {eb, ec, ed}) begin
      failures++;
      $display("FAIL %s: bit_id=%b bit_counter=%0d id_complete=%b, required bit_id=%b bit_counter=%0d id_complete=%b",
               name, bit_id, bit_counter, id_complete, eb, ec, ed);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; sample_point = 1'b0;
    tx_request = 1'b0; sof_complete = 1'b0; identifier = '0;
    tick(); tick();
    expect_out("reset_state", 1'b1, 4'd0, 1'b0);
    reset = 1'b0; enable = 1'b1;
    tick();
    expect_out("idle_after_reset", 1'b1, 4'd0, 1'b0);
  endtask

  // Serializes one frame; identifier input is scrambled after load to prove it is latched.
  task automatic run_frame(input string name, input logic [10:0] id);
    identifier = id; tx_request = 1'b1; sof_complete = 1'b1;
    tick();
    identifier = ~id;
    expect_out({name, "_load"}, id[10], 4'd0, 1'b0);
    for (int unsigned k = 1; k <= 11; k++) begin
      pulse_sample();
      expect_out({name, "_bit"}, (k <= 10) ? id[10 - k] : id[0], 4'(k), (k == 11));
      if (k == 4) begin
        tick();
        expect_out({name, "_hold_no_sample"}, id[6], 4'd4, 1'b0);
      end
    end
    pulse_sample();
    expect_out({name, "_complete_ignores_sample"}, id[0], 4'd11, 1'b1);
    tx_request = 1'b0;
    tick();
    expect_out({name, "_back_to_idle"}, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic test_serialize();
    run_frame("ser", 11'b10101100111);
  endtask

  task automatic test_invalid_id();
    identifier = 11'h7FF; tx_request = 1'b1; sof_complete = 1'b1;
    for (int unsigned k = 1; k <= 11; k++) begin
      pulse_sample();
`ifdef ID_VALID_CHECK_EN
      expect_out("invalid_stays_idle", 1'b1, 4'd0, 1'b0);
`else
      // Load happened on the first edge; the first sample is counted after it.
      expect_out("7ff_accepted", 1'b1, 4'(k - 1), 1'b0);
`endif
    end
    tx_request = 1'b0;
    tick();
    expect_out("invalid_release", 1'b1, 4'd0, 1'b0);
  endtask

  task automatic test_enable();
    logic [10:0] id;
    id = 11'b00001110101;
    identifier = id; tx_request = 1'b1; sof_complete = 1'b1;
    tick();
    pulse_sample();
    expect_out("en_first", id[9], 4'd1, 1'b0);
    enable = 1'b0;
    pulse_sample();
    tick();
    expect_out("en_frozen", id[9], 4'd1, 1'b0);
    tx_request = 1'b0;
    tick();
    expect_out("en_frozen_req_drop", id[9], 4'd1, 1'b0);
    tx_request = 1'b1;
    enable = 1'b1;
    for (int unsigned k = 2; k <= 11; k++) pulse_sample();
    expect_out("en_resumed_done", id[0], 4'd11, 1'b1);
    tx_request = 1'b0;
    tick();
    expect_out("en_idle", 1'b1, 4'd0, 1'b0);
  endtask

  task automatic test_abort();
    identifier = 11'b01100110011; tx_request = 1'b1; sof_complete = 1'b1;
    tick();
    pulse_sample(); pulse_sample(); pulse_sample();
    expect_out("abort_pre", 1'b0, 4'd3, 1'b0);
    sof_complete = 1'b0;
    tick();
    expect_out("abort_sof_drop", 1'b1, 4'd0, 1'b0);
    tx_request = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] id;
    for (int unsigned f = 0; f < 3; f++) begin
      do id = 11'($urandom_range(0, 2047)); while (id[10:4] == 7'h7F);
      run_frame($sformatf("b2b%0d", f), id);
    end
  endtask

  task automatic test_reset_mid();
    identifier = 11'b11001010110; tx_request = 1'b1; sof_complete = 1'b1;
    tick();
    for (int unsigned k = 0; k < 5; k++) pulse_sample();
    expect_out("mid_pre_reset", 1'b0, 4'd5, 1'b0);
    reset = 1'b1; enable = 1'b0;
    tick();
    expect_out("mid_reset", 1'b1, 4'd0, 1'b0);
    reset = 1'b0; enable = 1'b1; tx_request = 1'b0;
    tick();
    expect_out("mid_reset_idle", 1'b1, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_serialize();
    test_invalid_id();
    test_enable();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_identifier.md
CAN_IDENTIFIER -- requirements
Module: can_identifier

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 enable  in  1  block enable; low freezes all state and outputs.
REQ-005 sample_point  in  1  one-clock pulse per CAN bit time; advances transmission.
REQ-006 tx_request  in  1  frame transmit request from controller.
REQ-007 sof_complete  in  1  start-of-frame bit finished; identifier field may begin.
REQ-008 identifier  in  11  base identifier, bit 10 transmitted first.
REQ-009 bit_id  out  1  identifier bit currently driven toward bus (1 = recessive).
REQ-010 bit_counter  out  4  number of identifier bits already sampled, 0..11.
REQ-011 id_complete  out  1  identifier field finished; level, held until request drops.

Function
REQ-012 The FSM SHALL have states IDLE, TRANSMIT, COMPLETE; registered outputs only.
REQ-013 All transitions and register updates SHALL occur only in clocks where enable=1; with enable=0, state, shift register, bit_id, bit_counter and id_complete hold; transmission resumes unchanged on re-enable.
REQ-014 IDLE: bit_id=1, bit_counter=0, id_complete=0.
REQ-015 IDLE->TRANSMIT when tx_request=1 and sof_complete=1 and the identifier is valid: latch identifier into an 11-bit shift register, drive bit_id=identifier[10] on the next clock, bit_counter=0.
REQ-016 Valid identifier: identifier[10:4] != 7'b1111111 (CAN rule); an invalid identifier keeps the FSM in IDLE, with id_complete=0 and bit_id=1.
REQ-017 TRANSMIT: on each clock with sample_point=1, bit_counter increments by 1 and bit_id takes the next lower identifier bit (MSB-first); without sample_point, outputs hold.
REQ-018 When the 11th sample_point is taken (bit_counter becomes 11): go to COMPLETE, set id_complete=1, bit_id=identifier[0] retained.
REQ-019 TRANSMIT aborts to IDLE (outputs per REQ-014) in the next enabled clock if tx_request or sof_complete drops.
REQ-020 COMPLETE: id_complete=1, bit_counter=11; further sample_points are ignored; go to IDLE when tx_request=0 or sof_complete=0.
REQ-021 The identifier input is sampled only at the IDLE->TRANSMIT load; changes during TRANSMIT have no effect.
REQ-022 bit_counter SHALL never exceed 11 (no wrap).

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, bit_id=1, bit_counter=0, id_complete=0, shift register=0, regardless of enable or of state (including mid-transmission).

Configuration
REQ-024 Macro ID_VALID_CHECK_EN defined: REQ-016 validity check enforced.
REQ-025 ID_VALID_CHECK_EN undefined: every identifier, including 11'h7FF, is accepted and transmitted.

Structure
REQ-026 Shared package can_pkg SHALL hold the FSM state enum, ID_WIDTH=11, ID_CNT_WIDTH=4 and RECESSIVE=1'b1.
REQ-027 The block SHALL be a single module; no sub-module.

Verification
REQ-028 identifier=11'b10101100111, tx_request=sof_complete=1, 11 sample_points -> bit_id sequence 1,0,1,0,1,1,0,0,1,1,1; after the 11th, id_complete=1, bit_counter=11.
REQ-029 ID_VALID_CHECK_EN set, identifier=11'h7FF, request held, 11 sample_points -> bit_counter=0, bit_id=1, id_complete=0 throughout.
REQ-030 identifier=11'b00001110101; enable low for 2 clocks after the 1st sample_point (sample_point pulsed while disabled) -> bit_counter stays 1, then resumes and reaches 11 after 11 enabled sample_points.
REQ-031 Three back-to-back frames with random valid identifiers, request dropped after each id_complete -> each frame returns to IDLE, then serializes its own identifier correctly.
REQ-032 reset asserted after 5 sample_points -> next clock bit_counter=0, bit_id=1, id_complete=0, state IDLE.
